// File: rtl/logic_arb_pkg.sv
// Shared types and constants for the two-requester logic-op arbiter.
package logic_arb_pkg;
  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

  localparam int STAT_W = 8;

  // Saturating increment for the optional grant counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise AND/OR/XOR/NAND unit, shared by the arbiter and the pin wrapper.
module logic_op_unit
  import logic_arb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_e          op,
  output logic [W-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic unit between two valid/ready requesters.
// Define LOGIC_ARB_STATS_EN to add saturating per-requester grant counters.
module logic_op_arbiter
  import logic_arb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [W-1:0]      req0_a,
  input  logic [W-1:0]      req0_b,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [W-1:0]      req1_a,
  input  logic [W-1:0]      req1_b,
  input  logic [1:0]        req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_id,
`ifdef LOGIC_ARB_STATS_EN
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1,
`endif
  output logic              busy
);
  state_e       state_q, state_d;
  logic         last_grant, grant, idle, accept;
  logic [W-1:0] a_q, b_q, y;
  op_e          op_q;
  logic         id_q;

  assign idle  = (state_q == S_IDLE);
  // Contest goes to whoever did not win last; a lone valid always wins.
  assign grant = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

  // rst_n gating keeps both readies low while reset is held.
  assign req0_ready = rst_n && idle && ena && req0_valid && !grant;
  assign req1_ready = rst_n && idle && ena && req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;
  assign busy       = !idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic_op_unit #(.W(W)) u_op (.a(a_q), .b(b_q), .op(op_q), .y(y));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_AND;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
    end else begin
      if (accept) begin
        a_q        <= grant ? req1_a : req0_a;
        b_q        <= grant ? req1_b : req0_b;
        op_q       <= op_e'(grant ? req1_op : req0_op);
        id_q       <= grant;
        last_grant <= grant;
      end
      if (state_q == S_EXEC) begin
        rsp_data  <= y;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end
      if (state_q == S_RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

`ifdef LOGIC_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready) grant_cnt0 <= sat_inc(grant_cnt0);
      if (req1_ready) grant_cnt1 <= sat_inc(grant_cnt1);
    end
  end
`endif
endmodule

// File: tb/tb_logic_op_arbiter.sv
// Randomized bench for logic_op_arbiter against a transaction-level reference model.
module tb_logic_op_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]   req0_op = '0, req1_op = '0;
  logic         req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [W-1:0] rsp_data;
`ifdef LOGIC_ARB_STATS_EN
  logic [7:0]   grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  logic_op_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
`ifdef LOGIC_ARB_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
    .busy(busy)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, its age in cycles, and who is preferred next.
  bit           m_out, m_pref, m_id;
  int           m_age, m_cnt0, m_cnt1;
  logic [W-1:0] m_data;

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, b, input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic model_reset();
    m_out = 0; m_pref = 0; m_id = 0; m_age = 0; m_cnt0 = 0; m_cnt1 = 0; m_data = '0;
  endtask

  task automatic cycle(input bit v0, input logic [W-1:0] a0, b0, input logic [1:0] o0,
                       input bit v1, input logic [W-1:0] a1, b1, input logic [1:0] o1,
                       input bit en, input bit rr);
    bit e0, e1, vis;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
    ena = en; rsp_ready = rr;
    #1;
    e0  = !m_out && en && v0 && (!v1 || !m_pref);
    e1  = !m_out && en && v1 && (!v0 ||  m_pref);
    vis = m_out && m_age >= 2;
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("rsp_valid", rsp_valid, vis);
    chk("busy", busy, m_out);
    if (vis) begin
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_id", rsp_id, m_id);
    end
`ifdef LOGIC_ARB_STATS_EN
    chk("grant_cnt0", grant_cnt0, m_cnt0);
    chk("grant_cnt1", grant_cnt1, m_cnt1);
`endif
    @(posedge clk);
    if (e0 || e1) begin
      m_out  = 1; m_age = 1; m_id = e1; m_pref = !e1;
      m_data = e1 ? ref_op(a1, b1, o1) : ref_op(a0, b0, o0);
      if (e0) m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
      if (e1) m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
    end else if (m_out) begin
      if (vis && rr) m_out = 0;
      else           m_age++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req0_valid = 1; req1_valid = 1; ena = 1; rsp_ready = 1;
    rst_n = 0;
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
`ifdef LOGIC_ARB_STATS_EN
    chk("rst_grant_cnt0", grant_cnt0, 0);
    chk("rst_grant_cnt1", grant_cnt1, 0);
`endif
    model_reset();
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    rst_n = 1;
  endtask

  task automatic rand_cycle();
    cycle($urandom_range(0, 1), W'($urandom), W'($urandom), 2'($urandom),
          $urandom_range(0, 1), W'($urandom), W'($urandom), 2'($urandom),
          $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0);
  endtask

  initial begin
    model_reset();
    // Reset with valids high, then first contest goes to requester 0.
    do_reset();
    cycle(1, 8'h11, 8'h22, 2'd0, 1, 8'h33, 8'h44, 2'd1, 1, 1);
    repeat (4) cycle(0, '0, '0, 2'd0, 0, '0, '0, 2'd0, 1, 1);

    // Single OR op from requester 0; inputs scrambled after accept.
    cycle(1, 8'hF0, 8'h3C, 2'd1, 0, '0, '0, 2'd0, 1, 1);
    repeat (4) cycle(1, 8'h00, 8'h00, 2'd3, 0, '0, '0, 2'd0, 1, 1);

    // Contention: both valid, XOR everywhere, must alternate.
    repeat (15) cycle(1, 8'hAA, 8'h0F, 2'd2, 1, 8'hAA, 8'h0F, 2'd2, 1, 1);

    // Backpressure on a NAND result.
    do_reset();
    cycle(1, 8'hFF, 8'h0F, 2'd3, 0, '0, '0, 2'd0, 1, 0);
    repeat (7) cycle(1, 8'h12, 8'h34, 2'd0, 1, 8'h56, 8'h78, 2'd1, 1, 0);
    repeat (3) cycle(0, '0, '0, 2'd0, 0, '0, '0, 2'd0, 1, 1);

    // Reset while in EXEC drops the op; next contest goes to requester 0.
    cycle(0, '0, '0, 2'd0, 1, 8'h0F, 8'hF0, 2'd1, 1, 1);
    do_reset();
    repeat (4) cycle(1, 8'hC3, 8'h5A, 2'd2, 1, 8'h3C, 8'h5A, 2'd0, 1, 1);

    // ena low in IDLE blocks accept; ena low mid-op lets it finish.
    repeat (3) cycle(0, '0, '0, 2'd0, 0, '0, '0, 2'd0, 1, 1);
    repeat (4) cycle(0, '0, '0, 2'd0, 1, 8'h81, 8'h18, 2'd1, 0, 1);
    cycle(0, '0, '0, 2'd0, 1, 8'h81, 8'h18, 2'd1, 1, 1);
    repeat (4) cycle(1, 8'h77, 8'h11, 2'd2, 1, 8'h81, 8'h18, 2'd1, 0, 1);

    // Random traffic.
    repeat (3000) rand_cycle();

    // Counter saturation: 300 requester-1 ops.
    do_reset();
    repeat (900) cycle(0, '0, '0, 2'd0, 1, W'($urandom), W'($urandom), 2'($urandom), 1, 1);
`ifdef LOGIC_ARB_STATS_EN
    #1;
    chk("sat_grant_cnt1", grant_cnt1, 255);
    chk("sat_grant_cnt0", grant_cnt0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
